fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: Fetch_Unit

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request, keeps the PC,
// parks one acknowledged instruction in a skid buffer while decode is stalled,
// and presents the IF/ID register to the rest of the pipeline.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [6:0]  op_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;

    logic [31:0] fetch_addr;
    logic [31:0] target_addr;

    // Word-aligned views of the PC and of the redirect target
    assign fetch_addr  = pc & 32'hFFFF_FFFC;
    assign target_addr = branch_target_i & 32'hFFFF_FFFC;

    // Outputs decoded from registered state
    assign imem_req_o  = (state == FETCH);
    assign imem_addr_o = fetch_addr;
    assign instr_o     = instr_q;
    assign pc_o        = pc_q;
    assign valid_o     = valid_q;
    assign op_o        = instr_q[6:0];

    // Fetch FSM, PC, skid buffer and IF/ID register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            skid_instr <= '0;
            skid_pc    <= '0;
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    if (branch_taken_i) begin
                        pc      <= target_addr;
                        instr_q <= NOP_INSTR;
                        pc_q    <= fetch_addr;
                        valid_q <= 1'b0;
                    end else if (flush_i) begin
                        instr_q <= NOP_INSTR;
                        pc_q    <= fetch_addr;
                        valid_q <= 1'b0;
                    end else if (stall_i) begin
                        // Decode cannot take the word: park it and stop requesting
                        if (imem_ack_i) begin
                            skid_instr <= imem_rdata_i;
                            skid_pc    <= fetch_addr;
                            pc         <= fetch_addr + 32'd4;
                            state      <= HOLD;
                        end
                    end else if (imem_ack_i) begin
                        instr_q <= imem_rdata_i;
                        pc_q    <= fetch_addr;
                        valid_q <= 1'b1;
                        pc      <= fetch_addr + 32'd4;
                    end else begin
                        instr_q <= NOP_INSTR;
                        pc_q    <= fetch_addr;
                        valid_q <= 1'b0;
                    end
                end

                HOLD: begin
                    if (branch_taken_i || flush_i) begin
                        // Parked word is younger than IF/ID, so it is squashed as well
                        if (branch_taken_i) begin
                            pc <= target_addr;
                        end
                        skid_instr <= '0;
                        skid_pc    <= '0;
                        instr_q    <= NOP_INSTR;
                        pc_q       <= fetch_addr;
                        valid_q    <= 1'b0;
                        state      <= FETCH;
                    end else if (!stall_i) begin
                        instr_q <= skid_instr;
                        pc_q    <= skid_pc;
                        valid_q <= 1'b1;
                        state   <= FETCH;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a transaction-level reference model predicts
// the outputs after every clock edge, the expectation is queued, and a monitor
// on the falling edge pops and compares it against the DUT.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  op;
    logic        valid;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ack_i     (imem_ack),
        .imem_rdata_i   (imem_rdata),
        .stall_i        (stall),
        .flush_i        (flush),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .instr_o        (instr),
        .pc_o           (pc),
        .op_o           (op),
        .valid_o        (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic        chk_pc;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    // Reference model: a running flag, a list of words waiting for decode,
    // the next address to fetch and what decode currently holds.
    logic        m_running;
    logic [63:0] m_parked[$];
    logic [31:0] m_next_addr;
    logic        m_valid;
    logic [31:0] m_instr;
    logic        m_pc_known;
    logic [31:0] m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_bubble();
        m_valid    = 1'b0;
        m_instr    = NOP_INSTR;
        m_pc_known = 1'b0;
    endtask

    task automatic model_update(input logic r, input logic s, input logic st, input logic fl,
                                input logic br, input logic [31:0] tgt,
                                input logic ak, input logic [31:0] data);
        if (r) begin
            m_running   = 1'b0;
            m_parked.delete();
            m_next_addr = RESET_PC & 32'hFFFF_FFFC;
            m_valid     = 1'b0;
            m_instr     = NOP_INSTR;
            m_pc_known  = 1'b1;
            m_pc        = '0;
        end else if (!m_running) begin
            if (s) m_running = 1'b1;
        end else if (br) begin
            m_next_addr = tgt & 32'hFFFF_FFFC;
            m_parked.delete();
            model_bubble();
        end else if (fl) begin
            m_parked.delete();
            model_bubble();
        end else if (m_parked.size() > 0) begin
            if (!st) begin
                logic [63:0] w;
                w          = m_parked.pop_front();
                m_pc       = w[63:32];
                m_instr    = w[31:0];
                m_valid    = 1'b1;
                m_pc_known = 1'b1;
            end
        end else if (st) begin
            if (ak) begin
                m_parked.push_back({m_next_addr, data});
                m_next_addr = m_next_addr + 32'd4;
            end
        end else if (ak) begin
            m_pc        = m_next_addr;
            m_instr     = data;
            m_valid     = 1'b1;
            m_pc_known  = 1'b1;
            m_next_addr = m_next_addr + 32'd4;
        end else begin
            model_bubble();
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, queue them
    task automatic step(input logic r, input logic s, input logic st, input logic fl,
                        input logic br, input logic [31:0] tgt,
                        input logic ak, input logic [31:0] data);
        exp_t e;
        rst           = r;
        start         = s;
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = tgt;
        imem_ack      = ak;
        imem_rdata    = data;
        model_update(r, s, st, fl, br, tgt, ak, data);
        e.req    = m_running && (m_parked.size() == 0);
        e.addr   = m_next_addr;
        e.valid  = m_valid;
        e.instr  = m_instr;
        e.chk_pc = m_pc_known;
        e.pc     = m_pc;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("imem_req", {31'b0, imem_req}, {31'b0, e.req});
            if (e.req) check("imem_addr", imem_addr, e.addr);
            check("valid", {31'b0, valid}, {31'b0, e.valid});
            check("instr", instr, e.instr);
            check("op", {25'b0, op}, {25'b0, e.instr[6:0]});
            if (e.chk_pc) check("pc", pc, e.pc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0; imem_ack = 1'b0; imem_rdata = '0;
        m_running = 1'b0; m_next_addr = RESET_PC; m_valid = 1'b0;
        m_instr = NOP_INSTR; m_pc_known = 1'b0; m_pc = '0;
        @(negedge clk);

        // Reset with start asserted: start must be ignored
        step(1, 1, 0, 0, 0, '0, 0, '0);
        step(1, 1, 0, 0, 0, '0, 0, '0);
        check("reset_req", {31'b0, imem_req}, 32'd0);
        check("reset_instr", instr, 32'h0000_0013);
        check("reset_op", {25'b0, op}, 32'h0000_0013);

        // Start and stream 0x33
        step(0, 1, 0, 0, 0, '0, 0, '0);
        step(0, 0, 0, 0, 0, '0, 1, 32'h0000_0033);
        check("stream_pc0", pc, 32'h0);
        check("stream_op", {25'b0, op}, 32'h0000_0033);
        step(0, 0, 0, 0, 0, '0, 1, 32'h0000_0033);
        check("stream_pc4", pc, 32'h4);

        // Ack at PC=8 with stall held for three cycles
        step(0, 0, 1, 0, 0, '0, 1, 32'h0000_0033);
        check("hold_req", {31'b0, imem_req}, 32'd0);
        check("hold_pc", pc, 32'h4);
        step(0, 0, 1, 0, 0, '0, 1, 32'hDEAD_BEEF);
        step(0, 0, 1, 0, 0, '0, 0, '0);
        step(0, 0, 0, 0, 0, '0, 0, '0);
        check("unstall_pc", pc, 32'h8);
        check("unstall_addr", imem_addr, 32'hC);

        // Branch, stall and ack in one cycle
        step(0, 0, 1, 0, 1, 32'h0000_0103, 1, 32'hBAD0_0033);
        check("branch_addr", imem_addr, 32'h100);
        check("branch_valid", {31'b0, valid}, 32'd0);

        // Memory wait at 0x20
        step(0, 0, 0, 0, 1, 32'h0000_0020, 0, '0);
        step(0, 0, 0, 0, 0, '0, 0, '0);
        step(0, 0, 0, 0, 0, '0, 0, '0);
        check("wait_addr", imem_addr, 32'h20);
        check("wait_instr", instr, 32'h13);
        step(0, 0, 0, 0, 0, '0, 1, 32'h0040_0093);

        // Wrap at the top of the address space
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, '0);
        step(0, 0, 0, 0, 0, '0, 1, 32'h0000_0513);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc", pc, 32'hFFFF_FFFC);

        // Reset while parked in HOLD
        step(0, 0, 1, 0, 0, '0, 1, 32'h1111_1133);
        step(0, 0, 1, 0, 0, '0, 0, '0);
        step(1, 0, 1, 0, 0, '0, 1, 32'h2222_2233);
        check("rst_hold_req", {31'b0, imem_req}, 32'd0);
        check("rst_hold_valid", {31'b0, valid}, 32'd0);
        step(0, 1, 0, 0, 0, '0, 0, '0);
        check("rst_hold_addr", imem_addr, RESET_PC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, st, fl, br, ak;
            logic [31:0] tgt, data;
            r    = ($urandom_range(0, 249) == 0);
            s    = ($urandom_range(0, 1) == 0);
            st   = ($urandom_range(0, 9) < 3);
            fl   = ($urandom_range(0, 19) == 0);
            br   = ($urandom_range(0, 11) == 0);
            ak   = ($urandom_range(0, 9) < 7);
            tgt  = $urandom;
            data = $urandom;
            step(r, s, st, fl, br, tgt, ak, data);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
